// File: rtl/port_wrr_scheduler.sv
// Per-output-port packet scheduler: picks the next priority queue to dequeue,
// by strict priority or by weighted round robin (credit[p] = p+1 per round).
// One packet in flight at a time; requests are gated by the port's ready.
//
// Handshake: rd_req/rd_prio are held stable from the cycle rd_req rises until
// the cycle rd_ack is sampled high, or until the request is withdrawn because
// ready or queue_nonempty[rd_prio] fell. rd_done is a one-cycle pulse that is
// only honoured in XFER.
module port_wrr_scheduler #(
  parameter int NPRIO = 8,
  parameter int PW    = 3,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPRIO-1:0] queue_nonempty,
  input  logic             ready,
  input  logic             wrr_enable,
  input  logic             rd_ack,
  input  logic             rd_done,
  output logic             rd_req,
  output logic [PW-1:0]    rd_prio,
  output logic             busy,
  output logic             round_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2,
    XFER  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    credit [NPRIO];
  logic             wrr_q;        // mode seen in the most recent ARB cycle
  logic             mode_rise;    // strict -> WRR switch seen in this ARB cycle
  logic [NPRIO-1:0] elig;
  logic             any_ne;
  logic [PW-1:0]    sel;
  logic             do_latch;
  logic             do_reload;
  logic             do_spend;

  // Highest set bit wins: a larger priority index is more urgent.
  function automatic logic [PW-1:0] top_bit(input logic [NPRIO-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int p = 0; p < NPRIO; p++) begin
      if (v[p]) r = PW'(p);
    end
    return r;
  endfunction

  // Eligibility and selection; a mode switch into WRR counts as full credits.
  always_comb begin
    any_ne    = |queue_nonempty;
    mode_rise = (state == ARB) && wrr_enable && !wrr_q;
    for (int p = 0; p < NPRIO; p++) begin
      elig[p] = queue_nonempty[p] && (mode_rise || (credit[p] != '0));
    end
    sel = wrr_enable ? top_bit(elig) : top_bit(queue_nonempty);
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx  = state;
    do_latch  = 1'b0;
    do_reload = 1'b0;
    do_spend  = 1'b0;
    case (state)
      IDLE: begin
        if (ready && any_ne) state_nx = ARB;
      end
      ARB: begin
        if (!ready || !any_ne) begin
          state_nx = IDLE;
        end else if (wrr_enable && (elig == '0)) begin
          do_reload = 1'b1;
        end else begin
          do_latch = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (rd_ack) begin
          state_nx = XFER;
          do_spend = wrr_q;
        end else if (!ready || !queue_nonempty[rd_prio]) begin
          state_nx = IDLE;
        end
      end
      XFER: begin
        if (rd_done) state_nx = (ready && any_ne) ? ARB : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, selected queue, mode latch and round pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_prio    <= '0;
      wrr_q      <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state      <= state_nx;
      round_done <= do_reload;
      if (do_latch) rd_prio <= sel;
      if (state == ARB) wrr_q <= wrr_enable;
    end
  end

  // WRR credits: reload on exhaustion or mode switch, spend one per accepted packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NPRIO; p++) credit[p] <= CW'(p + 1);
    end else if (do_reload || mode_rise) begin
      for (int p = 0; p < NPRIO; p++) credit[p] <= CW'(p + 1);
    end else if (do_spend && (credit[rd_prio] != '0)) begin
      credit[rd_prio] <= credit[rd_prio] - 1'b1;
    end
  end

  assign rd_req = (state == ISSUE);
  assign busy   = (state == ISSUE) || (state == XFER);

endmodule

// File: tb/tb_port_wrr_scheduler.sv
// Bench for port_wrr_scheduler: directed scenarios plus randomized phases,
// grants compared against a credit/priority reference model.
module tb_port_wrr_scheduler;

  localparam int NPRIO = 8;
  localparam int PW    = 3;
  localparam int CW    = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [NPRIO-1:0] queue_nonempty;
  logic             ready;
  logic             wrr_enable;
  logic             rd_ack;
  logic             rd_done;
  logic             rd_req;
  logic [PW-1:0]    rd_prio;
  logic             busy;
  logic             round_done;

  always #5 clk = ~clk;

  port_wrr_scheduler #(.NPRIO(NPRIO), .PW(PW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .queue_nonempty(queue_nonempty), .ready(ready),
    .wrr_enable(wrr_enable), .rd_ack(rd_ack), .rd_done(rd_done),
    .rd_req(rd_req), .rd_prio(rd_prio), .busy(busy), .round_done(round_done)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: credits as plain integers, one round = p+1 grants of queue p.
  int cr [NPRIO];
  bit prev_mode;
  int exp_rounds = 0;
  int obs_rounds = 0;

  always @(negedge clk) if (!rst && round_done === 1'b1) obs_rounds++;

  task automatic model_reset();
    for (int p = 0; p < NPRIO; p++) cr[p] = p + 1;
    prev_mode = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_pick(input logic [NPRIO-1:0] ne, input bit mode);
    int sel;
    bit any;
    sel = 0;
    if (!mode) begin
      for (int p = NPRIO - 1; p >= 0; p--) if (ne[p] && sel == 0 && p > 0) begin sel = p; break; end
    end else begin
      if (!prev_mode) for (int p = 0; p < NPRIO; p++) cr[p] = p + 1;
      any = 1'b0;
      for (int p = 0; p < NPRIO; p++) if (ne[p] && cr[p] > 0) any = 1'b1;
      if (!any) begin
        for (int p = 0; p < NPRIO; p++) cr[p] = p + 1;
        exp_rounds++;
      end
      for (int p = NPRIO - 1; p > 0; p--) if (ne[p] && cr[p] > 0) begin sel = p; break; end
    end
    prev_mode = mode;
    exp_q.push_back(PW'(sel));
  endtask

  task automatic model_spend(input int p, input bit mode);
    if (mode && cr[p] > 0) cr[p]--;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; queue_nonempty = '0; ready = 1'b0; wrr_enable = 1'b0;
    rd_ack = 1'b0; rd_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_req(output bit ok);
    int t;
    t = 0;
    while (rd_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    ok = (t < 20);
    check("req_timeout", 32'(ok), 1);
  endtask

  // One full packet: wait for request, check pick, ack, transfer, done.
  task automatic do_grant(input bit last);
    bit ok;
    logic [PW-1:0] e;
    logic [PW-1:0] p0;
    @(negedge clk);
    wait_req(ok);
    if (!ok) return;
    model_pick(queue_nonempty, wrr_enable);
    e = exp_q.pop_front();
    check("grant_prio", 32'(rd_prio), 32'(e));
    p0 = rd_prio;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("req_hold", 32'(rd_req), 1);
      check("prio_hold", 32'(rd_prio), 32'(p0));
    end
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    model_spend(int'(e), wrr_enable);
    check("xfer_req", 32'(rd_req), 0);
    check("xfer_busy", 32'(busy), 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rd_done = 1'b1;
    if (last) ready = 1'b0;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  task automatic run_grants(input int n);
    for (int i = 0; i < n; i++) do_grant(i == n - 1);
    repeat (2) @(negedge clk);
    check("rounds", 32'(obs_rounds), 32'(exp_rounds));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    rst = 1'b1; queue_nonempty = '0; ready = 1'b0; wrr_enable = 1'b0;
    rd_ack = 1'b0; rd_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req", 32'(rd_req), 0);
    check("rst_prio", 32'(rd_prio), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_round", 32'(round_done), 0);
    rst = 1'b0;

    // strict priority, then the top queue drains
    wrr_enable = 1'b0; queue_nonempty = 8'b0010_1000; ready = 1'b1;
    run_grants(3);
    queue_nonempty = 8'b0000_1000; ready = 1'b1;
    run_grants(3);

    // WRR, all queues busy: one full round of 36 and a few more
    do_reset();
    wrr_enable = 1'b1; queue_nonempty = 8'hFF; ready = 1'b1;
    run_grants(40);

    // WRR, two queues
    do_reset();
    wrr_enable = 1'b1; queue_nonempty = 8'b0001_1000; ready = 1'b1;
    run_grants(20);

    // ready drops while the request is pending
    do_reset();
    wrr_enable = 1'b1; queue_nonempty = 8'b0001_1000; ready = 1'b1;
    @(negedge clk);
    wait_req(ok);
    check("wd_first_prio", 32'(rd_prio), 4);
    ready = 1'b0;
    @(negedge clk);
    check("wd_req_drop", 32'(rd_req), 0);
    check("wd_busy_drop", 32'(busy), 0);
    ready = 1'b1;
    @(negedge clk);
    check("wd_req_arb", 32'(rd_req), 0);
    @(negedge clk);
    check("wd_req_back", 32'(rd_req), 1);
    check("wd_prio_back", 32'(rd_prio), 4);
    run_grants(12);

    // selected queue empties in ISSUE; then ack and empty together
    do_reset();
    wrr_enable = 1'b1; queue_nonempty = 8'b0001_1000; ready = 1'b1;
    @(negedge clk);
    wait_req(ok);
    check("qc_first_prio", 32'(rd_prio), 4);
    queue_nonempty = 8'b0000_1000;
    @(negedge clk);
    check("qc_req_drop", 32'(rd_req), 0);
    wait_req(ok);
    model_pick(queue_nonempty, 1'b1);
    check("qc_next_prio", 32'(rd_prio), 32'(exp_q.pop_front()));
    rd_ack = 1'b1; queue_nonempty = '0;
    @(negedge clk);
    rd_ack = 1'b0;
    model_spend(3, 1'b1);
    check("qc_ack_xfer_req", 32'(rd_req), 0);
    check("qc_ack_xfer_busy", 32'(busy), 1);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    check("qc_idle_busy", 32'(busy), 0);
    queue_nonempty = 8'b0000_1000; ready = 1'b1;
    run_grants(5);

    // asynchronous reset mid-transfer
    do_reset();
    wrr_enable = 1'b1; queue_nonempty = 8'h01; ready = 1'b1;
    @(negedge clk);
    wait_req(ok);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check("ar_in_xfer", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_req", 32'(rd_req), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_prio", 32'(rd_prio), 0);
    check("ar_round", 32'(round_done), 0);
    @(negedge clk);
    model_reset();
    queue_nonempty = 8'h01; ready = 1'b1; rst = 1'b0;
    @(negedge clk);
    check("ar_req_n1", 32'(rd_req), 0);
    @(negedge clk);
    check("ar_req_n2", 32'(rd_req), 1);
    check("ar_prio_n2", 32'(rd_prio), 0);
    run_grants(3);

    // randomized phases: mode and queue mix change between packets
    do_reset();
    for (int ph = 0; ph < 12; ph++) begin
      wrr_enable     = 1'($urandom_range(0, 1));
      queue_nonempty = 8'($urandom_range(1, 255));
      ready          = 1'b1;
      run_grants(int'($urandom_range(4, 24)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
